rf_window_stream: RTL and testbench



---
 rtl/rf_window_stream.sv | 149 ++++++++++++++
 tb/tb_rf_window_stream.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_window_stream.sv
// Streaming receptive-field extractor: takes D-channel pixels in raster order,
// keeps the trailing F rows in a shift register and emits one F x F x D window
// per valid (strided) output position through a single valid/ready register.
module rf_window_stream #(
   parameter  int DATA_WIDTH = 32,
   parameter  int D          = 1,
   parameter  int H          = 48,
   parameter  int W          = 48,
   parameter  int F          = 5,
   parameter  int S          = 1,
   localparam int OH         = (H - F) / S + 1,
   localparam int OW         = (W - F) / S + 1,
   localparam int ORW        = (OH > 1) ? $clog2(OH) : 1,
   localparam int OCW        = (OW > 1) ? $clog2(OW) : 1,
   localparam int PW         = D * DATA_WIDTH,
   localparam int WW         = D * F * F * DATA_WIDTH
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           frame_clear,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [PW-1:0]  in_data,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [WW-1:0]  out_window,
   output logic [ORW-1:0] out_row,
   output logic [OCW-1:0] out_col,
   output logic           out_last
);

   localparam int RBW = (H > 1) ? $clog2(H) : 1;
   localparam int CBW = (W > 1) ? $clog2(W) : 1;
   // The incoming pixel is the window's bottom-right corner, so only the
   // (F-1) full rows plus F-1 pixels before it need to be held.
   localparam int SRL = (F - 1) * W + F - 1;
   localparam int SRN = (SRL > 0) ? SRL : 1;

   typedef enum logic {EMPTY, FULL} state_t;

   state_t           state, state_nxt;
   logic [RBW-1:0]   r;
   logic [CBW-1:0]   c;
   logic [PW-1:0]    sr [SRN];
   logic [WW-1:0]    win_nxt;
   logic [ORW-1:0]   row_nxt;
   logic [OCW-1:0]   col_nxt;
   logic             last_nxt;
   logic             hit;
   logic             accept;
   logic             load;

   assign out_valid = (state == FULL);
   assign in_ready  = !out_valid || out_ready;
   // A pixel arriving together with frame_clear is dropped.
   assign accept    = in_valid && in_ready && !frame_clear;
   assign load      = accept && hit;

   // Window gather: element (k,i,j) sits at a fixed distance back from the newest pixel.
   for (genvar i = 0; i < F; i++) begin : g_row
      for (genvar j = 0; j < F; j++) begin : g_col
         localparam int O = (F - 1 - i) * W + (F - 1 - j);
         for (genvar k = 0; k < D; k++) begin : g_ch
            if (O == 0) begin : g_new
               assign win_nxt[((k*F+i)*F+j)*DATA_WIDTH +: DATA_WIDTH] = in_data[k*DATA_WIDTH +: DATA_WIDTH];
            end else begin : g_old
               assign win_nxt[((k*F+i)*F+j)*DATA_WIDTH +: DATA_WIDTH] = sr[O-1][k*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   end

   // Decide whether the current pixel position completes a strided window.
   always_comb begin
      int tr, tc;
      tr       = int'(r) - (F - 1);
      tc       = int'(c) - (F - 1);
      hit      = 1'b0;
      row_nxt  = '0;
      col_nxt  = '0;
      last_nxt = 1'b0;
      if (tr >= 0 && tc >= 0 && (tr % S) == 0 && (tc % S) == 0) begin
         hit      = 1'b1;
         row_nxt  = ORW'(tr / S);
         col_nxt  = OCW'(tc / S);
         last_nxt = (tr / S == OH - 1) && (tc / S == OW - 1);
      end
   end

   // Output register occupancy: reload without a bubble when a transfer and a new window coincide.
   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY:   if (load) state_nxt = FULL;
         FULL:    if (load) state_nxt = FULL;
                  else if (out_ready) state_nxt = EMPTY;
         default: state_nxt = EMPTY;
      endcase
      if (frame_clear) state_nxt = EMPTY;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= EMPTY;
      else        state <= state_nxt;
   end

   // Raster position of the next pixel; wraps to a new frame after (H-1,W-1).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r <= '0;
         c <= '0;
      end else if (frame_clear) begin
         r <= '0;
         c <= '0;
      end else if (accept) begin
         if (c == CBW'(W - 1)) begin
            c <= '0;
            r <= (r == RBW'(H - 1)) ? '0 : r + 1'b1;
         end else begin
            c <= c + 1'b1;
         end
      end
   end

   // Pixel history; stale contents are never read before being overwritten.
   always_ff @(posedge clk) begin
      if (accept) begin
         sr[0] <= in_data;
         for (int k = 1; k < SRN; k++) sr[k] <= sr[k-1];
      end
   end

   // Output payload only changes on a load, so it holds while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_window <= '0;
         out_row    <= '0;
         out_col    <= '0;
         out_last   <= 1'b0;
      end else if (load) begin
         out_window <= win_nxt;
         out_row    <= row_nxt;
         out_col    <= col_nxt;
         out_last   <= last_nxt;
      end
   end

endmodule

// File: tb/tb_rf_window_stream.sv
// Bench for rf_window_stream: two instances (D=2 6x6 F=3 S=1, D=1 7x7 F=3 S=2)
// checked against a frame-image reference model and an expected-window queue.
module tb_rf_window_stream;
   localparam int DW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_n, frame_clear;
   logic [1:0]      iv, ir, ov, ordy, olast;
   logic [1:0][63:0] id;
   logic [1:0][1:0] orow, ocol;
   logic [575:0]    win0;
   logic [287:0]    win1;

   typedef struct {
      logic [575:0] w;
      int           row;
      int           col;
      bit           last;
   } exp_t;

   exp_t        q0[$], q1[$];
   logic [31:0] img [2][2][7][7];
   int          nerr = 0, nchk = 0, stalls = 0;

   rf_window_stream #(.DATA_WIDTH(DW), .D(2), .H(6), .W(6), .F(3), .S(1)) u0 (
      .clk(clk), .rst_n(rst_n), .frame_clear(frame_clear),
      .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
      .out_valid(ov[0]), .out_ready(ordy[0]), .out_window(win0),
      .out_row(orow[0]), .out_col(ocol[0]), .out_last(olast[0]));

   rf_window_stream #(.DATA_WIDTH(DW), .D(1), .H(7), .W(7), .F(3), .S(2)) u1 (
      .clk(clk), .rst_n(rst_n), .frame_clear(frame_clear),
      .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1][31:0]),
      .out_valid(ov[1]), .out_ready(ordy[1]), .out_window(win1),
      .out_row(orow[1]), .out_col(ocol[1]), .out_last(olast[1]));

   task automatic chk(input string tag, input logic [575:0] obs, input logic [575:0] exp_v);
      nchk++;
      if (obs !== exp_v) begin
         nerr++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [575:0] getwin(input int u);
      return (u != 0) ? {288'd0, win1} : win0;
   endfunction

   function automatic int wd(input int u);
      return (u != 0) ? 7 : 6;
   endfunction

   task automatic set_img(input int u, input bit rnd);
      for (int k = 0; k < 2; k++)
         for (int r = 0; r < 7; r++)
            for (int c = 0; c < 7; c++)
               img[u][k][r][c] = rnd ? $urandom : 32'(r * wd(u) + c + 100 * k);
   endtask

   // Reference: a window whose bottom-right is (r,c) exists when it fits and is on the stride grid.
   task automatic model_accept(input int u, input int r, input int c);
      int   s, oh, nd, tr, tc;
      exp_t e;
      s  = (u != 0) ? 2 : 1;
      oh = (u != 0) ? 3 : 4;
      nd = (u != 0) ? 1 : 2;
      tr = r - 2;
      tc = c - 2;
      if (tr >= 0 && tc >= 0 && tr % s == 0 && tc % s == 0) begin
         e.w    = '0;
         e.row  = tr / s;
         e.col  = tc / s;
         e.last = (e.row == oh - 1) && (e.col == oh - 1);
         for (int k = 0; k < nd; k++)
            for (int i = 0; i < 3; i++)
               for (int j = 0; j < 3; j++)
                  e.w[((k*3+i)*3+j)*DW +: DW] = img[u][k][tr+i][tc+j];
         if (u != 0) q1.push_back(e);
         else        q0.push_back(e);
      end
   endtask

   task automatic push_pixel(input int u, input int r, input int c, input bit rnd_rdy);
      logic acc;
      iv[u] = 1'b1;
      id[u] = {img[u][1][r][c], img[u][0][r][c]};
      for (int t = 0; ; t++) begin
         if (rnd_rdy) ordy[u] = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         acc = ir[u];
         @(posedge clk);
         if (acc) model_accept(u, r, c);
         #1;
         if (acc) break;
         stalls++;
         if (t > 100) begin
            chk("accept_timeout", 0, 1);
            break;
         end
      end
   endtask

   task automatic send_frame(input int u, input bit rnd_img, input bit gaps, input int npix);
      set_img(u, rnd_img);
      for (int p = 0; p < npix; p++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            iv[u] = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
         push_pixel(u, p / wd(u), p % wd(u), gaps);
      end
      iv[u]   = 1'b0;
      ordy[u] = 1'b1;
   endtask

   // Scoreboard: every transfer must match the next expected window; in_ready follows the handshake rule.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int u = 0; u < 2; u++) begin
            exp_t e;
            chk($sformatf("in_ready%0d", u), ir[u], !ov[u] || ordy[u]);
            if (ov[u] && ordy[u]) begin
               if ((u != 0) ? (q1.size() == 0) : (q0.size() == 0)) begin
                  chk($sformatf("unexpected_window%0d", u), 1, 0);
               end else begin
                  e = (u != 0) ? q1.pop_front() : q0.pop_front();
                  chk($sformatf("window%0d", u), getwin(u), e.w);
                  chk($sformatf("out_row%0d", u), orow[u], e.row);
                  chk($sformatf("out_col%0d", u), ocol[u], e.col);
                  chk($sformatf("out_last%0d", u), olast[u], e.last);
               end
            end
         end
      end
   end

   initial begin
      logic [575:0] snap_w;
      logic [1:0]   snap_r, snap_c;
      rst_n = 1'b0; frame_clear = 1'b0; iv = '0; ordy = 2'b11; id = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", ov[0], 0);
      chk("rst_window", win0, 0);
      chk("rst_row", orow[0], 0);
      chk("rst_col", ocol[0], 0);
      chk("rst_last", olast[0], 0);
      chk("rst_ready", ir[0], 1);
      chk("rst_valid1", ov[1], 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed 6x6, pixel = r*6+c, channel1 = channel0 + 100, held valid.
      set_img(0, 0);
      stalls = 0;
      for (int p = 0; p < 36; p++) begin
         push_pixel(0, p / 6, p % 6, 0);
         if (p == 14) begin
            chk("first_latency", ov[0], 1);
            chk("first_e100", win0[((1*3+0)*3+0)*DW +: DW], 100);
            chk("first_e14", win0[((0*3+2)*3+2)*DW +: DW], 14);
            chk("first_row", orow[0], 0);
            chk("first_col", ocol[0], 0);
         end
      end
      iv[0] = 1'b0;
      chk("last_flag", olast[0], 1);
      chk("last_row", orow[0], 3);
      chk("last_col", ocol[0], 3);
      chk("no_stall", stalls, 0);

      // Stride 2 on 7x7: directed, then random data with gaps and random ready.
      send_frame(1, 0, 0, 49);
      send_frame(1, 1, 1, 49);

      // Backpressure: hold ready low for 5 cycles while valid input keeps arriving.
      fork
         send_frame(0, 1, 0, 36);
         begin
            for (int t = 0; t < 100 && !ov[0]; t++) begin
               @(posedge clk); #1;
            end
            ordy[0] = 1'b0;
            snap_w = win0; snap_r = orow[0]; snap_c = ocol[0];
            repeat (5) begin
               @(negedge clk);
               chk("bp_ready", ir[0], 0);
               chk("bp_window", win0, snap_w);
               chk("bp_row", orow[0], snap_r);
               chk("bp_col", ocol[0], snap_c);
            end
            @(posedge clk); #1;
            ordy[0] = 1'b1;
         end
      join

      // Back-to-back frames with no gap, then random frames with gaps.
      stalls = 0;
      send_frame(0, 0, 0, 36);
      send_frame(0, 0, 0, 36);
      chk("b2b_no_stall", stalls, 0);
      send_frame(0, 1, 1, 36);
      send_frame(0, 1, 1, 36);

      // Asynchronous reset mid-frame after pixel 20 (a window is pending).
      set_img(0, 0);
      for (int p = 0; p <= 20; p++) push_pixel(0, p / 6, p % 6, 0);
      iv[0] = 1'b0;
      chk("prerst_valid", ov[0], 1);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", ov[0], 0);
      q0.delete(); q1.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      send_frame(0, 1, 0, 36);

      // frame_clear with a stalled pending window and a simultaneous valid pixel.
      set_img(0, 0);
      for (int p = 0; p <= 14; p++) push_pixel(0, p / 6, p % 6, 0);
      ordy[0] = 1'b0;
      iv[0] = 1'b1;
      id[0] = {img[0][1][2][3], img[0][0][2][3]};
      frame_clear = 1'b1;
      @(posedge clk); #1;
      chk("clear_valid", ov[0], 0);
      frame_clear = 1'b0;
      iv[0] = 1'b0;
      ordy[0] = 1'b1;
      q0.delete();
      send_frame(0, 1, 1, 36);

      for (int t = 0; t < 50 && (q0.size() != 0 || q1.size() != 0); t++) @(posedge clk);
      chk("drain0", q0.size(), 0);
      chk("drain1", q1.size(), 0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
